// File: rtl/osc_sample_arbiter.sv
// Round-robin readout of two channel sample FIFOs into one tagged, first-word fall-through output FIFO.
// Strobe at N, push at N+1, visible at N+2; reads stop issuing while the output FIFO is full or i_Enable=0.
module osc_sample_arbiter #(
    parameter int P_DEPTH = 4,
    parameter int P_BURST = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_Enable,
    output logic        o_ReadSample0,
    input  logic        i_ReadSampleEmpty0,
    input  logic [15:0] i_ReadSampleData0,
    output logic        o_ReadSample1,
    input  logic        i_ReadSampleEmpty1,
    input  logic [15:0] i_ReadSampleData1,
    input  logic        i_SampleRead,
    output logic        o_SampleEmpty,
    output logic [15:0] o_SampleData,
    output logic        o_SampleChan,
    output logic        o_Busy
);

    localparam int AW = $clog2(P_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_LIM = CW'(P_DEPTH);
    localparam logic [3:0]    BURST_LIM = 4'(P_BURST);

    typedef enum logic {IDLE, CAPTURE} state_t;

    state_t        state;
    logic          sel_chan;
    logic          last_chan;
    logic [3:0]    burst_cnt;
    logic          pick;
    logic          issue;
    logic          push;
    logic          pop;
    logic [16:0]   push_dat;
    logic [16:0]   head;
    logic [16:0]   mem [P_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] fifo_count;

    always_comb begin
        pick = 1'b0;
        if (!i_ReadSampleEmpty0 && !i_ReadSampleEmpty1)
            pick = (burst_cnt < BURST_LIM) ? last_chan : ~last_chan;
        else
            pick = !i_ReadSampleEmpty1;
        // Gated by reset so the strobes read zero while reset is held.
        issue = !reset && (state == IDLE) && i_Enable &&
                (!i_ReadSampleEmpty0 || !i_ReadSampleEmpty1) &&
                (fifo_count < DEPTH_LIM);
    end

    assign o_ReadSample0 = issue && !pick;
    assign o_ReadSample1 = issue && pick;
    assign o_Busy        = (state == CAPTURE);

    // burst_cnt resets saturated so the first tie after reset goes to the channel other than last_chan (ch0).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            sel_chan  <= 1'b0;
            last_chan <= 1'b1;
            burst_cnt <= 4'hF;
        end else begin
            case (state)
                IDLE: begin
                    if (issue) begin
                        state     <= CAPTURE;
                        sel_chan  <= pick;
                        last_chan <= pick;
                        if (pick != last_chan)
                            burst_cnt <= 4'd1;
                        else if (burst_cnt != 4'hF)
                            burst_cnt <= burst_cnt + 4'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign push     = (state == CAPTURE);
    assign push_dat = {sel_chan, sel_chan ? i_ReadSampleData1 : i_ReadSampleData0};
    assign pop      = i_SampleRead && (fifo_count != '0);

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= push_dat;
    end

    // head is a registered copy of the oldest entry; it keeps the last value once drained.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            head       <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)
                fifo_count <= fifo_count + 1'b1;
            else if (pop && !push)
                fifo_count <= fifo_count - 1'b1;
            if (pop && (fifo_count > CW'(1)))
                head <= mem[AW'(rd_ptr + 1'b1)];
            else if (push && ((fifo_count == '0) || pop))
                head <= push_dat;
        end
    end

    assign o_SampleEmpty = (fifo_count == '0);
    assign o_SampleData  = head[15:0];
    assign o_SampleChan  = head[16];

endmodule

// File: tb/tb_osc_sample_arbiter.sv
// Directed bench for osc_sample_arbiter: channel FIFO models feed the DUT, a scoreboard
// queue holds expected {chan,data} samples and a monitor compares every popped head.
module tb_osc_sample_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_Enable;
    logic        o_ReadSample0;
    logic        i_ReadSampleEmpty0;
    logic [15:0] i_ReadSampleData0;
    logic        o_ReadSample1;
    logic        i_ReadSampleEmpty1;
    logic [15:0] i_ReadSampleData1;
    logic        i_SampleRead;
    logic        o_SampleEmpty;
    logic [15:0] o_SampleData;
    logic        o_SampleChan;
    logic        o_Busy;

    logic [16:0] sb[$];
    logic [15:0] ch0_q[$];
    logic [15:0] ch1_q[$];
    int checks = 0;
    int errors = 0;
    int str_cnt0 = 0;
    int str_cnt1 = 0;
    int pop_budget = 0;
    bit pop_all = 1'b0;
    bit force_pop = 1'b0;
    int s0c, s1c;

    always #5 clk = ~clk;

    osc_sample_arbiter #(.P_DEPTH(4), .P_BURST(4)) dut (
        .clk               (clk),
        .reset             (reset),
        .i_Enable          (i_Enable),
        .o_ReadSample0     (o_ReadSample0),
        .i_ReadSampleEmpty0(i_ReadSampleEmpty0),
        .i_ReadSampleData0 (i_ReadSampleData0),
        .o_ReadSample1     (o_ReadSample1),
        .i_ReadSampleEmpty1(i_ReadSampleEmpty1),
        .i_ReadSampleData1 (i_ReadSampleData1),
        .i_SampleRead      (i_SampleRead),
        .o_SampleEmpty     (o_SampleEmpty),
        .o_SampleData      (o_SampleData),
        .o_SampleChan      (o_SampleChan),
        .o_Busy            (o_Busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Channel FIFO models: strobe sampled mid-cycle, word presented just after the edge.
    initial begin
        logic s0, s1;
        i_ReadSampleEmpty0 = 1'b1;
        i_ReadSampleEmpty1 = 1'b1;
        i_ReadSampleData0  = '0;
        i_ReadSampleData1  = '0;
        forever begin
            @(negedge clk);
            s0 = o_ReadSample0;
            s1 = o_ReadSample1;
            check("strobe_exclusive", 32'(s0 & s1), 32'd0);
            @(posedge clk);
            #1;
            if (s0) begin
                str_cnt0++;
                if (ch0_q.size() > 0) i_ReadSampleData0 = ch0_q.pop_front();
            end
            if (s1) begin
                str_cnt1++;
                if (ch1_q.size() > 0) i_ReadSampleData1 = ch1_q.pop_front();
            end
            i_ReadSampleEmpty0 = (ch0_q.size() == 0);
            i_ReadSampleEmpty1 = (ch1_q.size() == 0);
        end
    end

    // Output monitor: pops and checks the head against the scoreboard.
    initial begin
        logic [16:0] exp;
        i_SampleRead = 1'b0;
        forever begin
            @(negedge clk);
            i_SampleRead = 1'b0;
            if (force_pop) begin
                i_SampleRead = 1'b1;
            end else if ((pop_all || pop_budget > 0) && !o_SampleEmpty && !reset) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_sample: got chan %0d data 0x%0h, expected none",
                             o_SampleChan, o_SampleData);
                end else begin
                    exp = sb.pop_front();
                    check("sample", 32'({o_SampleChan, o_SampleData}), 32'(exp));
                end
                i_SampleRead = 1'b1;
                if (pop_budget > 0) pop_budget--;
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        i_Enable = 1'b0;
        tick(2);
        reset = 1'b0;
    endtask

    task automatic load(input int ch, input int n, input logic [15:0] base);
        for (int i = 0; i < n; i++) begin
            if (ch == 0) ch0_q.push_back(base + 16'(i));
            else         ch1_q.push_back(base + 16'(i));
        end
        i_ReadSampleEmpty0 = (ch0_q.size() == 0);
        i_ReadSampleEmpty1 = (ch1_q.size() == 0);
        #1;
    endtask

    task automatic expect_run(input logic ch, input logic [15:0] base, input int first, input int n);
        for (int i = first; i < first + n; i++) sb.push_back({ch, base + 16'(i)});
    endtask

    // 10+10 samples with a burst of 4: 4/4/4/4 then 2/2.
    task automatic expect_fair(input logic [15:0] b0, input logic [15:0] b1);
        expect_run(1'b0, b0, 0, 4);
        expect_run(1'b1, b1, 0, 4);
        expect_run(1'b0, b0, 4, 4);
        expect_run(1'b1, b1, 4, 4);
        expect_run(1'b0, b0, 8, 2);
        expect_run(1'b1, b1, 8, 2);
    endtask

    task automatic wait_drain(input string name, input int maxc);
        for (int i = 0; i < maxc; i++) begin
            if (sb.size() == 0) break;
            tick();
        end
        check({name, "_drained"}, 32'(sb.size()), 32'd0);
        tick(4);
        check({name, "_empty_after"}, 32'(o_SampleEmpty), 32'd1);
    endtask

    task automatic wait_strobe();
        for (int i = 0; i < 20; i++) begin
            if (o_ReadSample0 || o_ReadSample1) break;
            tick();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, expected completion");
        $fatal(1);
    end

    initial begin
        reset    = 1'b1;
        i_Enable = 1'b0;
        tick(2);
        check("rst_strobe0", 32'(o_ReadSample0), 32'd0);
        check("rst_strobe1", 32'(o_ReadSample1), 32'd0);
        check("rst_empty",   32'(o_SampleEmpty), 32'd1);
        check("rst_data",    32'(o_SampleData),  32'd0);
        check("rst_chan",    32'(o_SampleChan),  32'd0);
        check("rst_busy",    32'(o_Busy),        32'd0);

        // Single sample latency
        reset = 1'b0;
        s0c = str_cnt0;
        sb.push_back({1'b0, 16'h1234});
        load(0, 1, 16'h1234);
        i_Enable = 1'b1;
        #1;
        wait_strobe();
        check("single_strobe0", 32'(o_ReadSample0), 32'd1);
        check("single_strobe1", 32'(o_ReadSample1), 32'd0);
        tick();
        check("single_n1_empty", 32'(o_SampleEmpty), 32'd1);
        check("single_n1_busy",  32'(o_Busy),        32'd1);
        tick();
        check("single_n2_empty", 32'(o_SampleEmpty), 32'd0);
        check("single_n2_data",  32'(o_SampleData),  32'h1234);
        check("single_n2_chan",  32'(o_SampleChan),  32'd0);
        pop_budget = 1;
        tick(3);
        check("single_popped_empty", 32'(o_SampleEmpty), 32'd1);
        check("single_strobes", 32'(str_cnt0 - s0c), 32'd1);
        check("single_sb", 32'(sb.size()), 32'd0);

        // Fairness
        do_reset();
        s0c = str_cnt0;
        s1c = str_cnt1;
        pop_all = 1'b1;
        expect_fair(16'h0000, 16'h1000);
        load(0, 10, 16'h0000);
        load(1, 10, 16'h1000);
        i_Enable = 1'b1;
        wait_drain("fair", 120);
        check("fair_strobes0", 32'(str_cnt0 - s0c), 32'd10);
        check("fair_strobes1", 32'(str_cnt1 - s1c), 32'd10);
        pop_all = 1'b0;

        // Back-pressure
        do_reset();
        s0c = str_cnt0;
        expect_run(1'b0, 16'h2000, 0, 8);
        load(0, 8, 16'h2000);
        i_Enable = 1'b1;
        tick(20);
        check("bp_full_strobes", 32'(str_cnt0 - s0c), 32'd4);
        check("bp_full_busy",    32'(o_Busy),          32'd0);
        check("bp_full_head",    32'(o_SampleData),    32'h2000);
        pop_budget = 1;
        tick(10);
        check("bp_one_pop_strobes", 32'(str_cnt0 - s0c), 32'd5);
        pop_all = 1'b1;
        wait_drain("bp", 80);
        check("bp_total_strobes", 32'(str_cnt0 - s0c), 32'd8);
        pop_all = 1'b0;

        // Enable dropped during CAPTURE
        do_reset();
        s1c = str_cnt1;
        pop_all = 1'b1;
        expect_run(1'b1, 16'h3000, 0, 3);
        load(1, 3, 16'h3000);
        i_Enable = 1'b1;
        #1;
        wait_strobe();
        check("en_strobe1", 32'(o_ReadSample1), 32'd1);
        tick();
        check("en_capture_busy", 32'(o_Busy), 32'd1);
        i_Enable = 1'b0;
        tick(8);
        check("en_gated_strobes", 32'(str_cnt1 - s1c), 32'd1);
        check("en_inflight_pushed", 32'(sb.size()), 32'd2);
        i_Enable = 1'b1;
        wait_drain("en", 40);
        check("en_total_strobes", 32'(str_cnt1 - s1c), 32'd3);
        pop_all = 1'b0;

        // Async reset with 3 buffered and one in flight
        do_reset();
        s0c = str_cnt0;
        load(0, 6, 16'h4000);
        i_Enable = 1'b1;
        for (int i = 0; i < 30; i++) begin
            if (o_Busy && (str_cnt0 - s0c == 4)) break;
            tick();
        end
        check("ar_setup_busy",  32'(o_Busy),        32'd1);
        check("ar_setup_empty", 32'(o_SampleEmpty), 32'd0);
        #1;
        reset = 1'b1;
        #1;
        check("ar_empty",   32'(o_SampleEmpty), 32'd1);
        check("ar_data",    32'(o_SampleData),  32'd0);
        check("ar_chan",    32'(o_SampleChan),  32'd0);
        check("ar_busy",    32'(o_Busy),        32'd0);
        check("ar_strobe0", 32'(o_ReadSample0), 32'd0);
        tick(2);
        load(1, 1, 16'h5000);
        check("ar_held_strobe1", 32'(o_ReadSample1), 32'd0);
        sb.push_back({1'b0, 16'h4004});
        sb.push_back({1'b0, 16'h4005});
        sb.push_back({1'b1, 16'h5000});
        reset = 1'b0;
        #1;
        check("ar_first_ch0", 32'(o_ReadSample0), 32'd1);
        check("ar_first_not_ch1", 32'(o_ReadSample1), 32'd0);
        pop_all = 1'b1;
        wait_drain("ar", 40);
        pop_all = 1'b0;

        // Pops while empty, then 20 samples through the 4-deep FIFO
        do_reset();
        force_pop = 1'b1;
        tick(3);
        force_pop = 1'b0;
        tick();
        check("pe_empty", 32'(o_SampleEmpty), 32'd1);
        check("pe_data",  32'(o_SampleData),  32'd0);
        pop_all = 1'b1;
        expect_fair(16'h6000, 16'h7000);
        load(0, 10, 16'h6000);
        load(1, 10, 16'h7000);
        i_Enable = 1'b1;
        wait_drain("wrap", 120);
        check("wrap_hold_data", 32'(o_SampleData), 32'h7009);
        check("wrap_hold_chan", 32'(o_SampleChan), 32'd1);
        pop_all  = 1'b0;
        i_Enable = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/osc_sample_arbiter.md
# osc_sample_arbiter

Round-robin readout scheduler that drains the two channel sample FIFOs of the oscilloscope into one tagged sample stream for the user interface. It sits between the two channel blocks (their ReadSample/ReadSampleEmpty/ReadSampleData ports) and the user-side sample reader. It replaces the direct "whichever read strobe is high" data mux with a sequenced, fair, back-pressured path. It owns a small output FIFO, so the user side never talks to the channel FIFOs directly.

## Interface
- P_DEPTH, 4, output FIFO depth in samples; power of two, 2..16
- P_BURST, 4, maximum consecutive samples taken from one channel while the other channel is non-empty; 1..15
- clk  in  1  system clock; all logic rising-edge
- reset  in  1  asynchronous, active-high; clears all state
- i_Enable  in  1  master enable; 0 blocks issuing new channel reads
- o_ReadSample0  out  1  one-cycle read strobe to channel 0 FIFO
- i_ReadSampleEmpty0  in  1  channel 0 FIFO empty
- i_ReadSampleData0  in  16  channel 0 sample; valid the cycle after o_ReadSample0
- o_ReadSample1  out  1  one-cycle read strobe to channel 1 FIFO
- i_ReadSampleEmpty1  in  1  channel 1 FIFO empty
- i_ReadSampleData1  in  16  channel 1 sample; valid the cycle after o_ReadSample1
- i_SampleRead  in  1  user pop; acts only when o_SampleEmpty=0
- o_SampleEmpty  out  1  output FIFO empty
- o_SampleData  out  16  head sample (first-word fall-through); valid while o_SampleEmpty=0
- o_SampleChan  out  1  channel id of head sample
- o_Busy  out  1  channel read in flight (state CAPTURE)

## Operation
- FSM states: IDLE, CAPTURE.
- IDLE -> CAPTURE occurs when i_Enable=1, a channel is selected, and (fifo_count + 0) < P_DEPTH. In that cycle the FSM pulses the selected o_ReadSampleN and latches sel_chan.
- CAPTURE -> IDLE is unconditional. In that cycle the FSM pushes {sel_chan, i_ReadSampleData[sel_chan]} into the output FIFO.
- Selection in IDLE:
  - If only one channel is non-empty, select it.
  - If both are non-empty, stay on last_chan while burst_cnt < P_BURST; otherwise select the other channel.
  - After reset, last_chan=1, so channel 0 wins the first tie.
- burst_cnt (4 bits):
  - Reset to 1 when the selected channel differs from last_chan; otherwise increment.
  - Saturates at 15.
  - last_chan updates on every issue.
- Output FIFO:
  - Circular buffer of P_DEPTH entries of 17 bits, with wrapping read/write pointers and a count of width log2(P_DEPTH)+1.
  - Push and pop in the same cycle leave count unchanged.
  - A pop while empty is ignored; pointers are unchanged.
  - Overflow is impossible by construction, because issue requires count < P_DEPTH and at most one read is in flight.
  - The issue check uses the count at the IDLE cycle. A pop in that same cycle does not matter, since no other push can land before the CAPTURE push.
- i_Enable falling during CAPTURE: the in-flight sample is still pushed, and no further reads are issued. Buffered samples remain poppable regardless of i_Enable.
- Reset mid-operation: the FIFO, FSM, burst_cnt and last_chan are cleared. Buffered and in-flight samples are discarded. A channel FIFO word already popped is lost, which is accepted behaviour.

## Timing
- Reset values:
  - o_ReadSample0 = 0, o_ReadSample1 = 0
  - o_SampleEmpty = 1
  - o_SampleData = 0, o_SampleChan = 0
  - o_Busy = 0
- Read strobes are registered-free decodes of the IDLE state and selection; they are high for exactly one cycle per issue and never both high.
- Latency: strobe at cycle N, push at N+1, o_SampleEmpty=0 with data at N+2 when the FIFO was empty.
- Peak throughput is one sample per 2 cycles.
- o_SampleData and o_SampleChan update the cycle after a pop; when the FIFO is empty they hold the last entry's value.

## Test plan
- Single sample: ch0 holds 0x1234, ch1 empty, i_Enable=1.
  - Expect one o_ReadSample0 pulse, then o_SampleEmpty falls 2 cycles after the strobe.
  - Head shows 0x1234 with o_SampleChan=0; after one i_SampleRead, o_SampleEmpty=1.
- Fairness: both channels hold 10 samples (ch0 0x0000.., ch1 0x1000..), P_BURST=4, user pops continuously.
  - Expected channel order: 4×ch0, 4×ch1, 4×ch0, 4×ch1, then the remainder 2×ch0, 2×ch1.
  - Data per channel stays in order.
- Back-pressure: ch0 holds 8 samples, no pops.
  - Expect exactly P_DEPTH=4 strobes, after which count=4 and the strobes stop.
  - One pop causes exactly one new strobe.
- Enable gating: drop i_Enable in the CAPTURE cycle.
  - The in-flight sample is pushed, with no further strobes.
  - Re-raising i_Enable resumes reads with no sample lost or duplicated.
- Async reset: assert reset mid-stream with 3 samples buffered and a read in flight.
  - All outputs go to their reset values immediately, before the next clk edge.
  - After release, the first issue goes to ch0 when both channels are non-empty.
- Pop-while-empty plus wrap: issue 3 pops with the FIFO empty, then stream 20 samples through.
  - No corruption; the pointers wrap correctly over five FIFO depths.
